pp_pipeline_accel_sdiv_32s_32s_32_seq: RTL and testbench

- Iterative signed integer divider; the inverse-operation companion to the accelerator's pipelined signed multipliers.
- Used by pp_pipeline_accel scaling/normalisation stages that need quotient = din0 / din1.
- Radix-2 non-performing (restoring) shift-subtract core, one quotient bit per enabled cycle.
- start/done handshake with ready; global ce stall compatible with the HLS-style pipeline.

---
 rtl/pp_pipeline_accel_sdiv_32s_32s_32_seq_if.sv | 30 +++
 rtl/pp_pipeline_accel_sdiv_32s_32s_32_seq.sv | 123 ++++++++++++
 tb/tb_pp_pipeline_accel_sdiv_32s_32s_32_seq.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pp_pipeline_accel_sdiv_32s_32s_32_seq_if.sv
// Handshake/data bundle for the iterative signed divider.
// Master drives ce/start/operands; slave returns ready/done/quotient/flag.
// Optional rem_out is present only when PP_SDIV_REMAINDER_EN is defined.
interface pp_pipeline_accel_sdiv_32s_32s_32_seq_if #(
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 32,
  parameter int dout_WIDTH = 32
);
  logic                  ce;
  logic                  start;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  ready;
  logic                  done;
  logic [dout_WIDTH-1:0] dout;
  logic                  div_by_zero;
`ifdef PP_SDIV_REMAINDER_EN
  logic [din1_WIDTH-1:0] rem_out;

  modport master (output ce, start, din0, din1,
                  input  ready, done, dout, div_by_zero, rem_out);
  modport slave  (input  ce, start, din0, din1,
                  output ready, done, dout, div_by_zero, rem_out);
`else
  modport master (output ce, start, din0, din1,
                  input  ready, done, dout, div_by_zero);
  modport slave  (input  ce, start, din0, din1,
                  output ready, done, dout, div_by_zero);
`endif
endinterface

// File: rtl/pp_pipeline_accel_sdiv_32s_32s_32_seq.sv
// Iterative signed divider (restoring shift-subtract, one quotient bit per enabled cycle).
// Latency N+2 enabled cycles from accept to done; ce=0 freezes everything, start ignored while busy.
// Build option PP_SDIV_REMAINDER_EN adds a signed remainder output (rem_out).
module pp_pipeline_accel_sdiv_32s_32s_32_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 32,
  parameter int dout_WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  pp_pipeline_accel_sdiv_32s_32s_32_seq_if.slave bus
);
  localparam int N  = din0_WIDTH;
  localparam int M  = din1_WIDTH;
  localparam int W1 = N + 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [N-1:0]          dvd;     // dividend magnitude, becomes the quotient magnitude
  logic [N:0]            rem;     // partial remainder
  logic [N:0]            dsr;     // divisor magnitude
  logic                  q_sign;
  logic                  zero;
  logic                  done_r;
  logic                  dz_r;
  logic [dout_WIDTH-1:0] dout_r;
`ifdef PP_SDIV_REMAINDER_EN
  logic                  r_sign;  // remainder takes the dividend's sign
  logic [M-1:0]          din0_lo; // returned as the remainder on divide by zero
  logic [M-1:0]          rem_r;
`endif

  logic [N-1:0] a0;
  logic [N:0]   b_ext;
  logic [N:0]   a1;
  logic [N+1:0] rem_sh;
  logic         ge;
  logic [N:0]   rem_nx;
  logic [N-1:0] qs;

  // Operand magnitudes at accept, one restoring step, and the signed quotient.
  always_comb begin
    // |MIN| = 2^(N-1) still fits an unsigned N-bit magnitude
    a0     = bus.din0[N-1] ? (~bus.din0 + N'(1)) : bus.din0;
    b_ext  = {{(W1-M){bus.din1[M-1]}}, bus.din1};
    a1     = b_ext[N] ? (~b_ext + W1'(1)) : b_ext;
    rem_sh = {rem, dvd[N-1]};
    ge     = (rem_sh >= {1'b0, dsr});
    rem_nx = ge ? W1'(rem_sh - {1'b0, dsr}) : rem_sh[N:0];
    qs     = q_sign ? (~dvd + N'(1)) : dvd;
  end

  assign bus.ready       = (state == IDLE);
  assign bus.done        = done_r;
  assign bus.dout        = dout_r;
  assign bus.div_by_zero = dz_r;
`ifdef PP_SDIV_REMAINDER_EN
  assign bus.rem_out     = rem_r;
`endif

  // Control FSM and datapath; every update is gated by ce.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      dvd     <= '0;
      rem     <= '0;
      dsr     <= '0;
      q_sign  <= 1'b0;
      zero    <= 1'b0;
      done_r  <= 1'b0;
      dz_r    <= 1'b0;
      dout_r  <= '0;
`ifdef PP_SDIV_REMAINDER_EN
      r_sign  <= 1'b0;
      din0_lo <= '0;
      rem_r   <= '0;
`endif
    end else if (bus.ce) begin
      // done is a single enabled-cycle pulse unless FIX re-asserts it
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd     <= a0;
            dsr     <= a1;
            rem     <= '0;
            q_sign  <= bus.din0[N-1] ^ bus.din1[M-1];
            zero    <= (bus.din1 == '0);
            cnt     <= CW'(N - 1);
            state   <= CALC;
`ifdef PP_SDIV_REMAINDER_EN
            r_sign  <= bus.din0[N-1];
            din0_lo <= M'(bus.din0);
`endif
          end
        end
        CALC: begin
          rem <= rem_nx;
          dvd <= {dvd[N-2:0], ge};
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - CW'(1);
        end
        FIX: begin
          dout_r <= zero ? '1 : dout_WIDTH'(qs);
          dz_r   <= zero;
          done_r <= 1'b1;
          state  <= IDLE;
`ifdef PP_SDIV_REMAINDER_EN
          rem_r  <= zero ? din0_lo : M'(r_sign ? (~rem + W1'(1)) : rem);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pp_pipeline_accel_sdiv_32s_32s_32_seq.sv
// Self-checking bench for the iterative signed divider.
// Directed table run back-to-back, ce-stall and reset-abort sequences, then random ops vs a model.
// Remainder checks are compiled in when PP_SDIV_REMAINDER_EN is defined.
module tb_pp_pipeline_accel_sdiv_32s_32s_32_seq;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  pp_pipeline_accel_sdiv_32s_32s_32_seq_if bus ();

  pp_pipeline_accel_sdiv_32s_32s_32_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    bit dz;
  } vec_t;

  localparam int MIN = 32'h8000_0000;
  localparam int MAX = 32'h7FFF_FFFF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain truncating division with the documented special cases.
  function automatic int model_q(input int a, input int b);
    if (b == 0) return -1;
    if (a == MIN && b == -1) return MIN;
    return a / b;
  endfunction

  function automatic int model_r(input int a, input int b);
    if (b == 0) return a;
    if (a == MIN && b == -1) return 0;
    return a % b;
  endfunction

  // Issue a request in the current cycle (ready assumed high) and count edges to done.
  task automatic do_op(input int a, input int b, input bit junk, output int ncyc);
    bus.start = 1'b1;
    bus.din0  = a;
    bus.din1  = b;
    ncyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      ncyc++;
      if (junk && ncyc < 20) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.din0  = $urandom;
        bus.din1  = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) break;
    end
  endtask

  function automatic int pick();
    int sel;
    sel = int'($urandom_range(0, 7));
    case (sel)
      0: return 0;
      1: return 1;
      2: return -1;
      3: return MIN;
      4: return MAX;
      default: return int'($urandom);
    endcase
  endfunction

  vec_t tv[$];
  int   n;
  int   en;
  int   busy_rdy;
  int   a, b;
  bit   ce_at;

  initial begin
    reset     = 1'b1;
    bus.ce    = 1'b1;
    bus.start = 1'b0;
    bus.din0  = '0;
    bus.din1  = '0;

    tv.push_back('{a: 100,    b: 7,   q: 14,   r: 2,   dz: 1'b0});
    tv.push_back('{a: -100,   b: 7,   q: -14,  r: -2,  dz: 1'b0});
    tv.push_back('{a: 100,    b: -7,  q: -14,  r: 2,   dz: 1'b0});
    tv.push_back('{a: -100,   b: -7,  q: 14,   r: -2,  dz: 1'b0});
    tv.push_back('{a: MIN,    b: -1,  q: MIN,  r: 0,   dz: 1'b0});
    tv.push_back('{a: MIN,    b: 1,   q: MIN,  r: 0,   dz: 1'b0});
    tv.push_back('{a: 7,      b: 0,   q: -1,   r: 7,   dz: 1'b1});
    tv.push_back('{a: 0,      b: 5,   q: 0,    r: 0,   dz: 1'b0});
    tv.push_back('{a: MAX,    b: -1,  q: -MAX, r: 0,   dz: 1'b0});
    tv.push_back('{a: -1,     b: 2,   q: 0,    r: -1,  dz: 1'b0});
    tv.push_back('{a: 5,      b: MIN, q: 0,    r: 5,   dz: 1'b0});
    tv.push_back('{a: MIN,    b: MIN, q: 1,    r: 0,   dz: 1'b0});
    tv.push_back('{a: MAX,    b: MAX, q: 1,    r: 0,   dz: 1'b0});
    tv.push_back('{a: -12345, b: 0,   q: -1,   r: -12345, dz: 1'b1});

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_dout",  bus.dout, 32'd0);
    chk("rst_dz",    32'(bus.div_by_zero), 32'd0);
`ifdef PP_SDIV_REMAINDER_EN
    chk("rst_rem",   bus.rem_out, 32'd0);
`endif
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors, each start issued in the previous done cycle.
    foreach (tv[i]) begin
      do_op(tv[i].a, tv[i].b, 1'b0, n);
      chk($sformatf("vec%0d_lat", i),   32'(n), 32'd34);
      chk($sformatf("vec%0d_done", i),  32'(bus.done), 32'd1);
      chk($sformatf("vec%0d_ready", i), 32'(bus.ready), 32'd1);
      chk($sformatf("vec%0d_dout", i),  bus.dout, tv[i].q);
      chk($sformatf("vec%0d_dz", i),    32'(bus.div_by_zero), 32'(tv[i].dz));
`ifdef PP_SDIV_REMAINDER_EN
      chk($sformatf("vec%0d_rem", i),   bus.rem_out, tv[i].r);
`endif
    end

    // ce toggling with start held high for the whole operation.
    bus.start = 1'b1;
    bus.din0  = 1000;
    bus.din1  = 10;
    bus.ce    = 1'b1;
    en = 0;
    busy_rdy = 0;
    for (int i = 0; i < 200; i++) begin
      ce_at = bus.ce;
      @(posedge clk);
      if (ce_at) en++;
      #1;
      if (bus.done) break;
      if (bus.ready) busy_rdy++;
      bus.ce = ~bus.ce;
    end
    chk("ce_enabled_edges", 32'(en), 32'd34);
    chk("ce_no_reaccept",   32'(busy_rdy), 32'd0);
    chk("ce_dout",          bus.dout, 32'd100);
    bus.ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("ce_hold_done%0d", i), 32'(bus.done), 32'd1);
      chk($sformatf("ce_hold_dout%0d", i), bus.dout, 32'd100);
    end
    bus.start = 1'b0;
    bus.ce    = 1'b1;
    @(posedge clk);
    #1;
    chk("ce_done_drop", 32'(bus.done), 32'd0);
    chk("ce_idle",      32'(bus.ready), 32'd1);

    // Reset in the middle of a request: no done for it, next request normal.
    bus.start = 1'b1;
    bus.din0  = 12345;
    bus.din1  = 5;
    n = 0;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (cyc == 10) begin
        reset = 1'b1;
        #1;
        chk("midrst_ready", 32'(bus.ready), 32'd1);
        chk("midrst_done",  32'(bus.done), 32'd0);
        chk("midrst_dout",  bus.dout, 32'd0);
        chk("midrst_dz",    32'(bus.div_by_zero), 32'd0);
`ifdef PP_SDIV_REMAINDER_EN
        chk("midrst_rem",   bus.rem_out, 32'd0);
`endif
      end
      if (cyc == 11) reset = 1'b0;
      if (bus.done) n++;
    end
    do_op(9, 3, 1'b0, en);
    chk("midrst_stale_done", 32'(n), 32'd0);
    chk("midrst_lat",  32'(12 + en), 32'd46);
    chk("midrst_dout2", bus.dout, 32'd3);

    // Random operands, with junk start/operand activity while busy.
    for (int k = 0; k < 1200; k++) begin
      a = pick();
      b = pick();
      do_op(a, b, 1'($urandom_range(0, 1)), n);
      chk("rnd_lat",  32'(n), 32'd34);
      chk("rnd_dout", bus.dout, model_q(a, b));
      chk("rnd_dz",   32'(bus.div_by_zero), 32'(b == 0));
`ifdef PP_SDIV_REMAINDER_EN
      chk("rnd_rem",  bus.rem_out, model_r(a, b));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
